beep_sequencer: RTL and testbench

BEEP_SEQUENCER -- requirements
Module: beep_sequencer

---
 rtl/parking_pkg.sv | 34 +++
 rtl/ms_tick.sv | 33 +++
 rtl/beep_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_beep_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking-sensor beep path.
`timescale 1ns/1ps
package parking_pkg;

    typedef logic [11:0] dist_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_CONT = 2'd3
    } beep_state_t;

    localparam logic [7:0] TONE_CODE_DEFAULT = 8'h1C;
    localparam int         NEAR_CM_DEFAULT   = 20;
    localparam int         FAR_CM_DEFAULT    = 200;
    localparam dist_t      ZONE_MID_CM       = 12'd100;

    // Proximity band reported to the display: 3 nearest, 0 out of range.
    function automatic logic [1:0] zone_of(input dist_t d, input dist_t near_cm, input dist_t far_cm);
        logic [1:0] z;
        if (d <= near_cm) begin
            z = 2'd3;
        end else if (d >= far_cm) begin
            z = 2'd0;
        end else if (d >= ZONE_MID_CM) begin
            z = 2'd1;
        end else begin
            z = 2'd2;
        end
        return z;
    endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clocks.
`timescale 1ns/1ps
module ms_tick #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter with registered tick on wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/beep_sequencer.sv
// Turns ranged distance into a beep cadence: faster as the obstacle nears,
// continuous when very close, silent when far, disabled or data is stale.
`timescale 1ns/1ps
module beep_sequencer
    import parking_pkg::*;
#(
    parameter int         TICK_DIV   = 50000,
    parameter int         NEAR_CM    = NEAR_CM_DEFAULT,
    parameter int         FAR_CM     = FAR_CM_DEFAULT,
    parameter int         BEEP_MS    = 60,
    parameter int         TIMEOUT_MS = 500,
    parameter logic [7:0] TONE_CODE  = TONE_CODE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] distance,
    input  logic        flag,
    input  logic        enable,
    output logic [7:0]  key_code,
    output logic        beep,
    output logic [1:0]  zone,
    output logic        stale
);

    localparam int              TO_W     = (TIMEOUT_MS > 0) ? $clog2(TIMEOUT_MS + 1) : 1;
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_MS);
    localparam dist_t           NEAR_D   = dist_t'(NEAR_CM);
    localparam dist_t           FAR_D    = dist_t'(FAR_CM);
    localparam logic [9:0]      BEEP_CNT = 10'(BEEP_MS);

    logic            tick_s;
    dist_t           d_q_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [TO_W-1:0] to_cnt_next_s;
    logic            stale_r;
    beep_state_t     state_r;
    beep_state_t     state_next_s;
    logic [9:0]      cnt_r;
    logic [9:0]      cnt_next_s;
    logic [9:0]      cnt_dec_s;
    logic [12:0]     off_ms_s;
    logic            near_s;
    logic            force_idle_s;
    logic            expired_s;
    logic            beep_next_s;
    logic            beep_r;
    logic [7:0]      key_code_r;
    logic [1:0]      zone_r;

    ms_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Timeout counter: a fresh measurement always beats a coincident tick.
    always_comb begin
        to_cnt_next_s = to_cnt_r;
        if (flag) begin
            to_cnt_next_s = '0;
        end else if (tick_s && (to_cnt_r != TO_MAX)) begin
            to_cnt_next_s = to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_next_s = to_cnt_r;
        end
    end

    // Gap after each beep grows 2 ms per cm beyond the near threshold.
    always_comb begin
        off_ms_s     = 13'd0;
        near_s       = (d_q_r <= NEAR_D);
        force_idle_s = !enable || stale_r || (d_q_r >= FAR_D);
        expired_s    = (cnt_r == 10'd0) || (tick_s && (cnt_r == 10'd1));
        cnt_dec_s    = (tick_s && (cnt_r != 10'd0)) ? (cnt_r - 10'd1) : cnt_r;
        if (d_q_r > NEAR_D) begin
            off_ms_s = {d_q_r - NEAR_D, 1'b0};
        end else begin
            off_ms_s = 13'd0;
        end
    end

    // Cadence FSM next-state and period counter.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (force_idle_s) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 10'd0;
                end else if (near_s) begin
                    state_next_s = ST_CONT;
                    cnt_next_s   = 10'd0;
                end else begin
                    state_next_s = ST_ON;
                    cnt_next_s   = BEEP_CNT;
                end
            end
            ST_ON: begin
                if (force_idle_s) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 10'd0;
                end else if (expired_s) begin
                    if (off_ms_s == 13'd0) begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = 10'd0;
                    end else begin
                        state_next_s = ST_OFF;
                        cnt_next_s   = off_ms_s[9:0];
                    end
                end else begin
                    cnt_next_s = cnt_dec_s;
                end
            end
            ST_OFF: begin
                if (force_idle_s) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 10'd0;
                end else if (near_s) begin
                    state_next_s = ST_CONT;
                    cnt_next_s   = 10'd0;
                end else if (expired_s) begin
                    state_next_s = ST_ON;
                    cnt_next_s   = BEEP_CNT;
                end else if (off_ms_s < {3'b000, cnt_dec_s}) begin
                    cnt_next_s = off_ms_s[9:0];
                end else begin
                    cnt_next_s = cnt_dec_s;
                end
            end
            ST_CONT: begin
                if (force_idle_s) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 10'd0;
                end else if (!near_s) begin
                    state_next_s = ST_OFF;
                    cnt_next_s   = off_ms_s[9:0];
                end else begin
                    state_next_s = ST_CONT;
                    cnt_next_s   = 10'd0;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 10'd0;
            end
        endcase
        beep_next_s = (state_next_s == ST_ON) || (state_next_s == ST_CONT);
    end

    // Distance latch and measurement-age tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q_r    <= 12'hFFF;
            to_cnt_r <= TO_MAX;
            stale_r  <= 1'b1;
        end else begin
            if (flag) begin
                d_q_r <= distance;
            end
            to_cnt_r <= to_cnt_next_s;
            stale_r  <= (to_cnt_next_s == TO_MAX);
        end
    end

    // State register and registered tone outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 10'd0;
            beep_r     <= 1'b0;
            key_code_r <= 8'h00;
            zone_r     <= 2'd0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            beep_r     <= beep_next_s;
            key_code_r <= beep_next_s ? TONE_CODE : 8'h00;
            zone_r     <= (!enable || stale_r) ? 2'd0 : zone_of(d_q_r, NEAR_D, FAR_D);
        end
    end

    assign beep     = beep_r;
    assign key_code = key_code_r;
    assign zone     = zone_r;
    assign stale    = stale_r;

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer with a 4-cycle millisecond tick.
`timescale 1ns/1ps
module tb_beep_sequencer;

    logic        clk;
    logic        reset;
    logic [11:0] distance;
    logic        flag;
    logic        enable;
    logic [7:0]  key_code;
    logic        beep;
    logic [1:0]  zone;
    logic        stale;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n;
    int viol;

    beep_sequencer #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .distance (distance),
        .flag     (flag),
        .enable   (enable),
        .key_code (key_code),
        .beep     (beep),
        .zone     (zone),
        .stale    (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks since reset release; tick is high in cycles where cyc%4==0.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected in [%0d,%0d]", tag, obs, lo, hi);
        end
    endtask

    task automatic pulse(input logic [11:0] d);
        distance = d;
        flag     = 1'b1;
        @(negedge clk);
        flag     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic count_level(input logic lvl, input int lim, output int cnt);
        cnt = 0;
        while (beep === lvl && cnt < lim) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic wait_level(input logic lvl, input int lim, output int cnt);
        cnt = 0;
        while (beep !== lvl && cnt < lim) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        reset    = 1'b1;
        flag     = 1'b0;
        distance = 12'd0;
        enable   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_stale", stale, 1);
        check("rst_beep", beep, 0);
        check("rst_key", key_code, 8'h00);
        check("rst_zone", zone, 0);
        reset = 1'b0;

        viol = 0;
        repeat (200) begin
            @(negedge clk);
            if (beep !== 1'b0 || stale !== 1'b1 || key_code !== 8'h00 || zone !== 2'd0) viol++;
        end
        check("no_flag_quiet", viol, 0);

        // 150 cm: 60 ms on, 260 ms off.
        pulse(12'd150);
        check("d150_latency_beep0", beep, 0);
        @(negedge clk);
        check("d150_beep", beep, 1);
        check("d150_key", key_code, 8'h1C);
        check("d150_zone", zone, 1);
        check("d150_stale", stale, 0);
        count_level(1'b1, 400, n);
        check_range("d150_first_on", n, 237, 240);
        check("d150_off_key", key_code, 8'h00);
        check("d150_off_zone", zone, 1);
        count_level(1'b0, 1200, n);
        check("d150_off_len", n, 1040);
        repeat (10) @(negedge clk);
        check("d150_mid_on", beep, 1);
        enable = 1'b0;
        @(negedge clk);
        check("enable_drop_beep", beep, 0);
        check("enable_drop_zone", zone, 0);
        enable = 1'b1;

        // 15 cm continuous, then 50 cm gives 60 ms gaps.
        do_reset();
        pulse(12'd15);
        check("d15_latency_beep0", beep, 0);
        @(negedge clk);
        check("d15_beep", beep, 1);
        check("d15_zone", zone, 3);
        check("d15_key", key_code, 8'h1C);
        count_level(1'b1, 100, n);
        check("d15_continuous", n, 100);
        pulse(12'd50);
        check("d50_cont_hold", beep, 1);
        @(negedge clk);
        check("d50_off_beep", beep, 0);
        check("d50_zone", zone, 2);
        count_level(1'b0, 400, n);
        check_range("d50_first_off", n, 237, 240);
        count_level(1'b1, 400, n);
        check("d50_on_len", n, 240);

        // Truncate a long gap to the shorter one for 40 cm.
        do_reset();
        pulse(12'd150);
        @(negedge clk);
        count_level(1'b1, 400, n);
        repeat (240) @(negedge clk);
        check("trunc_still_off", beep, 0);
        pulse(12'd40);
        wait_level(1'b1, 1200, n);
        check_range("trunc_remaining", n, 158, 161);
        check("trunc_zone", zone, 2);
        count_level(1'b1, 400, n);
        check("d40_on_len", n, 240);
        count_level(1'b0, 400, n);
        check("d40_off_len", n, 160);

        // Flag coincident with tick, then 500 ms of silence from the ranger.
        do_reset();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cyc > 0 && (cyc % 4) == 0) && n < 8);
        distance = 12'd50;
        flag     = 1'b1;
        @(negedge clk);
        flag     = 1'b0;
        check("flag_tick_stale_clear", stale, 0);
        n = 0;
        while (stale === 1'b0 && n < 2500) begin
            @(negedge clk);
            n++;
        end
        check("timeout_len", n, 2000);
        check("timeout_beep_before", beep, 1);
        @(negedge clk);
        check("timeout_beep_after", beep, 0);
        check("timeout_zone", zone, 0);
        check("timeout_key", key_code, 8'h00);

        // Reset during continuous tone; reset beats a simultaneous flag.
        pulse(12'd15);
        @(negedge clk);
        check("cont_before_reset", beep, 1);
        reset    = 1'b1;
        flag     = 1'b1;
        distance = 12'd15;
        @(negedge clk);
        check("reset_cont_beep", beep, 0);
        check("reset_cont_key", key_code, 8'h00);
        check("reset_cont_stale", stale, 1);
        reset = 1'b0;
        flag  = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_over_flag_beep", beep, 0);
        check("reset_over_flag_stale", stale, 1);

        // Distance boundaries.
        pulse(12'd250);
        repeat (3) @(negedge clk);
        check("d250_beep", beep, 0);
        check("d250_zone", zone, 0);
        check("d250_stale", stale, 0);
        pulse(12'd0);
        @(negedge clk);
        check("d0_beep", beep, 1);
        check("d0_zone", zone, 3);
        pulse(12'd200);
        @(negedge clk);
        check("d200_beep", beep, 0);
        check("d200_zone", zone, 0);
        pulse(12'd199);
        @(negedge clk);
        check("d199_beep", beep, 1);
        check("d199_zone", zone, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
